// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared parameters and types for the register scoreboard
// Purpose: default sizing for the scoreboard and the register index type.
// Ports: none (package).
package pipe_pkg;

  localparam int NREG_DEF   = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int STAT_W_DEF = 16;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating up/down in-flight write counter with clear
// Purpose: tracks outstanding writes to one architectural register.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear, dominates inc/dec
//   inc, dec     count up / down; both together leave the count unchanged
//   cnt          current count (W bits)
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      // Writeback of a register with nothing in flight is dropped.
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard with RAW/saturation stall and stall statistics
// Purpose: tracks in-flight writes per register and holds decode on hazards.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   decode holds a valid instruction
//   id_rs1/id_rs2, *_used      source indices and whether they are read
//   id_rd, id_wr               destination index and write enable
//   wb_valid, wb_rd            writeback completing this cycle
//   flush                      clears all tracking on the next edge
//   stall, issue               decode hold / instruction accepted
//   busy_vec                   per-register non-zero counter flags
//   stall_cycles               saturating stall-cycle count
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        id_rd,
  input  logic              id_wr,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [NREG-1:0]   busy_vec,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic raw_hazard;
  logic sat_hazard;

  // Register 0 is hardwired: no counter, never busy.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic inc;
    logic dec;
    assign inc = issue && id_wr && (id_rd == reg_idx_t'(i));
    assign dec = wb_valid && (wb_rd == reg_idx_t'(i));

    sb_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (inc),
      .dec   (dec),
      .cnt   (cnt[i])
    );

    assign busy_vec[i] = |cnt[i];
  end

  // Hazards look only at registered counters, so a same-cycle writeback
  // does not release the stall until the following cycle.
  assign raw_hazard = (id_rs1_used && busy_vec[id_rs1]) ||
                      (id_rs2_used && busy_vec[id_rs2]);
  // A further write would overflow the destination counter.
  assign sat_hazard = id_wr && (id_rd != '0) && (cnt[id_rd] == CNT_MAX);

  assign stall = id_valid && !flush && (raw_hazard || sat_hazard);
  assign issue = id_valid && !stall && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != STAT_MAX)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_wr, wb_valid, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        stall, issue;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: outstanding writes per register, stall statistic.
  int m_cnt[32];
  int m_stat;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_wr        (id_wr),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .stall        (stall),
    .issue        (issue),
    .busy_vec     (busy_vec),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic wr; logic wbv; logic [4:0] wbr; logic fl;
    logic e_stall; logic e_issue; logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic v, input int rs1, input logic u1,
                              input int rs2, input logic u2, input int rd,
                              input logic wr, input logic wbv, input int wbr,
                              input logic fl, input logic es, input logic ei,
                              input logic [31:0] eb);
    vec_t r;
    r.v = v; r.rs1 = 5'(rs1); r.u1 = u1; r.rs2 = 5'(rs2); r.u2 = u2;
    r.rd = 5'(rd); r.wr = wr; r.wbv = wbv; r.wbr = 5'(wbr); r.fl = fl;
    r.e_stall = es; r.e_issue = ei; r.e_busy = eb;
    return r;
  endfunction

  function automatic logic [31:0] b(input int k);
    logic [31:0] one;
    one = 32'h1;
    return one << k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_wr = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_stat = 0;
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] r;
    r = '0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic m_stall();
    logic [31:0] bz;
    logic raw, sat;
    bz  = m_busy();
    raw = (id_rs1_used && bz[id_rs1]) || (id_rs2_used && bz[id_rs2]);
    sat = id_wr && (id_rd != 0) && (m_cnt[id_rd] == 3);
    return id_valid && !flush && (raw || sat);
  endfunction

  // Apply what the next clock edge does to the reference state.
  task automatic model_edge();
    logic st, is;
    int inc_i, dec_i;
    st = m_stall();
    is = id_valid && !st && !flush;
    if (st && m_stat < 65535) m_stat++;
    inc_i = (is && id_wr && id_rd != 0) ? int'(id_rd) : -1;
    dec_i = (wb_valid && wb_rd != 0) ? int'(wb_rd) : -2;
    if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else if (inc_i != dec_i) begin
      if (inc_i > 0 && m_cnt[inc_i] < 3) m_cnt[inc_i]++;
      if (dec_i > 0 && m_cnt[dec_i] > 0) m_cnt[dec_i]--;
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #3;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_stat", 32'(stall_cycles), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    next();
    rst_n = 1;
    id_valid = 1;
    #1;
    chk("rst_issue_eq_valid", 32'(issue), 32'h1);
    idle();
    next();

    // Directed vectors: one row per cycle, expectations are pre-edge values.
    tbl[0]  = mk(0, 0,0, 0,0,  0,0, 0,0, 0, 0,0, 32'h0);
    tbl[1]  = mk(1, 0,0, 0,0,  5,1, 0,0, 0, 0,1, 32'h0);
    tbl[2]  = mk(1, 5,1, 0,0,  0,0, 1,5, 0, 1,0, b(5));
    tbl[3]  = mk(1, 5,1, 0,0,  0,0, 0,0, 0, 0,1, 32'h0);
    tbl[4]  = mk(1, 0,0, 0,0,  0,1, 0,0, 0, 0,1, 32'h0);
    tbl[5]  = mk(1, 0,1, 0,1,  0,0, 0,0, 0, 0,1, 32'h0);
    tbl[6]  = mk(1, 0,0, 0,0,  7,1, 0,0, 0, 0,1, 32'h0);
    tbl[7]  = mk(1, 0,0, 0,0,  7,1, 0,0, 0, 0,1, b(7));
    tbl[8]  = mk(1, 0,0, 0,0,  7,1, 0,0, 0, 0,1, b(7));
    tbl[9]  = mk(1, 0,0, 0,0,  7,1, 1,7, 0, 1,0, b(7));
    tbl[10] = mk(1, 0,0, 0,0,  7,1, 0,0, 0, 0,1, b(7));
    tbl[11] = mk(1, 0,0, 0,0,  7,1, 0,0, 1, 0,0, b(7));
    tbl[12] = mk(1, 0,0, 0,0,  3,1, 0,0, 0, 0,1, 32'h0);
    tbl[13] = mk(1, 0,0, 0,0,  3,1, 1,3, 0, 0,1, b(3));
    tbl[14] = mk(0, 0,0, 0,0,  0,0, 1,3, 0, 0,0, b(3));
    tbl[15] = mk(1, 0,0, 0,0,  2,1, 0,0, 0, 0,1, 32'h0);
    tbl[16] = mk(1, 0,0, 0,0,  9,1, 0,0, 0, 0,1, b(2));
    tbl[17] = mk(1, 0,0, 0,0, 31,1, 0,0, 0, 0,1, b(2) | b(9));
    tbl[18] = mk(1, 0,0, 0,0,  4,1, 0,0, 1, 0,0, b(2) | b(9) | b(31));
    tbl[19] = mk(0, 0,0, 0,0,  0,0, 1,9, 0, 0,0, 32'h0);
    tbl[20] = mk(1, 9,1, 0,0,  0,0, 0,0, 0, 0,1, 32'h0);

    for (int r = 0; r < 21; r++) begin
      id_valid = tbl[r].v; id_rs1 = tbl[r].rs1; id_rs1_used = tbl[r].u1;
      id_rs2 = tbl[r].rs2; id_rs2_used = tbl[r].u2; id_rd = tbl[r].rd;
      id_wr = tbl[r].wr; wb_valid = tbl[r].wbv; wb_rd = tbl[r].wbr;
      flush = tbl[r].fl;
      #1;
      chk($sformatf("tbl%0d_stall", r), 32'(stall), 32'(tbl[r].e_stall));
      chk($sformatf("tbl%0d_issue", r), 32'(issue), 32'(tbl[r].e_issue));
      chk($sformatf("tbl%0d_busy", r), busy_vec, tbl[r].e_busy);
      next();
    end
    idle();
    #1;
    chk("tbl_stat", 32'(stall_cycles), 32'd2);
    chk("tbl_busy_end", busy_vec, 32'h0);

    // Asynchronous reset between edges, then randomized run against the model.
    next();
    rst_n = 0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_stat", 32'(stall_cycles), 32'h0);
    model_reset();
    next();
    rst_n = 1;
    for (int c = 0; c < 2000; c++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_rd       = 5'($urandom_range(0, 7));
      id_wr       = ($urandom_range(0, 3) != 0);
      wb_valid    = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_stall", 32'(stall), 32'(m_stall()));
      chk("rnd_issue", 32'(issue), 32'(id_valid && !m_stall() && !flush));
      chk("rnd_busy", busy_vec, m_busy());
      chk("rnd_stat", 32'(stall_cycles), 32'(m_stat));
      model_edge();
      next();
    end

    // Long stall: statistic saturates, then async reset clears everything.
    idle();
    rst_n = 0;
    #1;
    rst_n = 1;
    next();
    id_valid = 1; id_rd = 5'd5; id_wr = 1;
    next();
    id_wr = 0; id_rd = 0; id_rs1 = 5'd5; id_rs1_used = 1;
    for (int c = 0; c < 70000; c++) @(posedge clk);
    #1;
    chk("sat_stat", 32'(stall_cycles), 32'h0000_FFFF);
    chk("sat_stall", 32'(stall), 32'h1);
    chk("sat_busy", busy_vec, b(5));
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_busy", busy_vec, 32'h0);
    chk("mid_rst_stat", 32'(stall_cycles), 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_issue", 32'(issue), 32'h1);
    next();
    rst_n = 1;
    next();
    #1;
    chk("post_rst_stat", 32'(stall_cycles), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
